// File: rtl/rob_dual_commit.sv
// Reorder buffer with two writeback ports, dual in-order commit, rename-bypass
// lookups and a registered misprediction / jalr redirect flush.
module rob_dual_commit #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_valid,
  input  logic [1:0]       alloc_kind,
  input  logic [4:0]       alloc_rd,
  input  logic [31:0]      alloc_pc,
  input  logic [31:0]      alloc_target,
  input  logic             alloc_pred,
  output logic [IDX_W-1:0] alloc_id,
  output logic             full_out,
  input  logic             wb0_valid,
  input  logic [IDX_W-1:0] wb0_id,
  input  logic [31:0]      wb0_val,
  input  logic             wb1_valid,
  input  logic [IDX_W-1:0] wb1_id,
  input  logic [31:0]      wb1_val,
  input  logic [IDX_W-1:0] q0_id,
  output logic             q0_ready,
  output logic [31:0]      q0_val,
  input  logic [IDX_W-1:0] q1_id,
  output logic             q1_ready,
  output logic [31:0]      q1_val,
  input  logic             mem_busy,
  output logic             cmt0_valid,
  output logic [IDX_W-1:0] cmt0_id,
  output logic [4:0]       cmt0_rd,
  output logic [31:0]      cmt0_val,
  output logic             cmt1_valid,
  output logic [IDX_W-1:0] cmt1_id,
  output logic [4:0]       cmt1_rd,
  output logic [31:0]      cmt1_val,
  output logic             store_commit,
  output logic             br_valid,
  output logic             br_taken,
  output logic             br_correct,
  output logic             flush_out,
  output logic [31:0]      flush_pc
);

  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_ST   = 2'd1;
  localparam logic [1:0] KIND_BR   = 2'd2;
  localparam logic [1:0] KIND_JALR = 2'd3;
  localparam logic [IDX_W:0] FULL_LVL = (IDX_W+1)'(DEPTH - 1);

  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, pred_q, pred_d;
  logic [1:0]       kind_q   [DEPTH];
  logic [1:0]       kind_d   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [4:0]       rd_d     [DEPTH];
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      pc_d     [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [31:0]      target_d [DEPTH];
  logic [31:0]      val_q    [DEPTH];
  logic [31:0]      val_d    [DEPTH];

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic             cmt0_valid_q, cmt0_valid_d, cmt1_valid_q, cmt1_valid_d;
  logic [IDX_W-1:0] cmt0_id_q, cmt0_id_d, cmt1_id_q, cmt1_id_d;
  logic [4:0]       cmt0_rd_q, cmt0_rd_d, cmt1_rd_q, cmt1_rd_d;
  logic [31:0]      cmt0_val_q, cmt0_val_d, cmt1_val_q, cmt1_val_d;
  logic             store_q, store_d, br_valid_q, br_valid_d;
  logic             br_taken_q, br_taken_d, br_correct_q, br_correct_d;
  logic             flush_q, flush_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

  logic [IDX_W-1:0] head1;
  logic [1:0]       kind0;
  logic             c0, c1, br_mis, flush_now, alloc_ok;

  assign full_out = (count_q >= FULL_LVL);
  assign alloc_id = tail_q;

  // Bypass priority: wb1 over wb0 over the stored result
  assign q0_ready = done_q[q0_id] || (wb0_valid && wb0_id == q0_id) || (wb1_valid && wb1_id == q0_id);
  assign q1_ready = done_q[q1_id] || (wb0_valid && wb0_id == q1_id) || (wb1_valid && wb1_id == q1_id);
  assign q0_val = (wb1_valid && wb1_id == q0_id) ? wb1_val :
                  (wb0_valid && wb0_id == q0_id) ? wb0_val : val_q[q0_id];
  assign q1_val = (wb1_valid && wb1_id == q1_id) ? wb1_val :
                  (wb0_valid && wb0_id == q1_id) ? wb0_val : val_q[q1_id];

  // Commit selection works only from registered state
  assign head1     = head_q + IDX_W'(1);
  assign kind0     = kind_q[head_q];
  assign c0        = valid_q[head_q] && done_q[head_q] && !(kind0 == KIND_ST && mem_busy);
  assign c1        = c0 && (kind0 == KIND_ALU) && valid_q[head1] && done_q[head1] &&
                     (kind_q[head1] == KIND_ALU);
  assign br_mis    = c0 && (kind0 == KIND_BR) && (val_q[head_q][0] != pred_q[head_q]);
  assign flush_now = br_mis || (c0 && kind0 == KIND_JALR);
  assign alloc_ok  = alloc_valid && !full_out && !flush_q;

  always_comb begin
    valid_d = valid_q;  done_d = done_q;  pred_d = pred_q;
    kind_d = kind_q;  rd_d = rd_q;  pc_d = pc_q;  target_d = target_q;  val_d = val_q;
    head_d = head_q;  tail_d = tail_q;  count_d = count_q;
    cmt0_valid_d = 1'b0;  cmt0_id_d = cmt0_id_q;  cmt0_rd_d = cmt0_rd_q;  cmt0_val_d = cmt0_val_q;
    cmt1_valid_d = 1'b0;  cmt1_id_d = cmt1_id_q;  cmt1_rd_d = cmt1_rd_q;  cmt1_val_d = cmt1_val_q;
    store_d = 1'b0;  br_valid_d = 1'b0;  br_taken_d = br_taken_q;  br_correct_d = br_correct_q;
    flush_d = 1'b0;  flush_pc_d = flush_pc_q;

    if (rdy_in) begin
      if (c0) begin
        cmt0_valid_d = 1'b1;
        cmt0_id_d    = head_q;
        cmt0_rd_d    = (kind0 == KIND_ALU || kind0 == KIND_JALR) ? rd_q[head_q] : 5'd0;
        cmt0_val_d   = (kind0 == KIND_JALR) ? pc_q[head_q] + 32'd4 : val_q[head_q];
        store_d      = (kind0 == KIND_ST);
        if (kind0 == KIND_BR) begin
          br_valid_d   = 1'b1;
          br_taken_d   = val_q[head_q][0];
          br_correct_d = !br_mis;
        end
      end
      if (c1) begin
        cmt1_valid_d = 1'b1;
        cmt1_id_d    = head1;
        cmt1_rd_d    = rd_q[head1];
        cmt1_val_d   = val_q[head1];
      end
      if (flush_now) begin
        flush_d    = 1'b1;
        flush_pc_d = (kind0 == KIND_JALR) ? {val_q[head_q][31:1], 1'b0} :
                     val_q[head_q][0]     ? target_q[head_q] : pc_q[head_q] + 32'd4;
        valid_d = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (wb0_valid && valid_q[wb0_id]) begin
          done_d[wb0_id] = 1'b1;
          val_d[wb0_id]  = wb0_val;
        end
        if (wb1_valid && valid_q[wb1_id]) begin
          done_d[wb1_id] = 1'b1;
          val_d[wb1_id]  = wb1_val;
        end
        if (alloc_ok) begin
          valid_d[tail_q]  = 1'b1;
          done_d[tail_q]   = 1'b0;
          kind_d[tail_q]   = alloc_kind;
          rd_d[tail_q]     = alloc_rd;
          pc_d[tail_q]     = alloc_pc;
          target_d[tail_q] = alloc_target;
          pred_d[tail_q]   = alloc_pred;
          tail_d           = tail_q + IDX_W'(1);
        end
        if (c0) valid_d[head_q] = 1'b0;
        if (c1) valid_d[head1]  = 1'b0;
        head_d  = head_q + IDX_W'(c0) + IDX_W'(c1);
        count_d = count_q + (IDX_W+1)'(alloc_ok) - (IDX_W+1)'(c0) - (IDX_W+1)'(c1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;  done_q <= '0;  pred_q <= '0;
      kind_q <= '{default: '0};  rd_q <= '{default: '0};  pc_q <= '{default: '0};
      target_q <= '{default: '0};  val_q <= '{default: '0};
      head_q <= '0;  tail_q <= '0;  count_q <= '0;
      cmt0_valid_q <= 1'b0;  cmt0_id_q <= '0;  cmt0_rd_q <= '0;  cmt0_val_q <= '0;
      cmt1_valid_q <= 1'b0;  cmt1_id_q <= '0;  cmt1_rd_q <= '0;  cmt1_val_q <= '0;
      store_q <= 1'b0;  br_valid_q <= 1'b0;  br_taken_q <= 1'b0;  br_correct_q <= 1'b0;
      flush_q <= 1'b0;  flush_pc_q <= '0;
    end else begin
      valid_q <= valid_d;  done_q <= done_d;  pred_q <= pred_d;
      kind_q <= kind_d;  rd_q <= rd_d;  pc_q <= pc_d;  target_q <= target_d;  val_q <= val_d;
      head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
      cmt0_valid_q <= cmt0_valid_d;  cmt0_id_q <= cmt0_id_d;
      cmt0_rd_q <= cmt0_rd_d;  cmt0_val_q <= cmt0_val_d;
      cmt1_valid_q <= cmt1_valid_d;  cmt1_id_q <= cmt1_id_d;
      cmt1_rd_q <= cmt1_rd_d;  cmt1_val_q <= cmt1_val_d;
      store_q <= store_d;  br_valid_q <= br_valid_d;
      br_taken_q <= br_taken_d;  br_correct_q <= br_correct_d;
      flush_q <= flush_d;  flush_pc_q <= flush_pc_d;
    end
  end

  assign cmt0_valid   = cmt0_valid_q;
  assign cmt0_id      = cmt0_id_q;
  assign cmt0_rd      = cmt0_rd_q;
  assign cmt0_val     = cmt0_val_q;
  assign cmt1_valid   = cmt1_valid_q;
  assign cmt1_id      = cmt1_id_q;
  assign cmt1_rd      = cmt1_rd_q;
  assign cmt1_val     = cmt1_val_q;
  assign store_commit = store_q;
  assign br_valid     = br_valid_q;
  assign br_taken     = br_taken_q;
  assign br_correct   = br_correct_q;
  assign flush_out    = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_rob_dual_commit.sv
// Bench for rob_dual_commit: directed retirement scenarios followed by random
// traffic, all checked cycle by cycle against an entry-table reference model.
module tb_rob_dual_commit;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
  logic alloc_valid = 1'b0, alloc_pred = 1'b0;
  logic [1:0] alloc_kind = '0;
  logic [4:0] alloc_rd = '0;
  logic [31:0] alloc_pc = '0, alloc_target = '0;
  logic [IDX_W-1:0] alloc_id;
  logic full_out;
  logic wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic [IDX_W-1:0] wb0_id = '0, wb1_id = '0, q0_id = '0, q1_id = '0;
  logic [31:0] wb0_val = '0, wb1_val = '0;
  logic q0_ready, q1_ready;
  logic [31:0] q0_val, q1_val;
  logic mem_busy = 1'b0;
  logic cmt0_valid, cmt1_valid;
  logic [IDX_W-1:0] cmt0_id, cmt1_id;
  logic [4:0] cmt0_rd, cmt1_rd;
  logic [31:0] cmt0_val, cmt1_val;
  logic store_commit, br_valid, br_taken, br_correct, flush_out;
  logic [31:0] flush_pc;

  rob_dual_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_target(alloc_target), .alloc_pred(alloc_pred),
    .alloc_id(alloc_id), .full_out(full_out),
    .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_val(wb0_val),
    .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_val(wb1_val),
    .q0_id(q0_id), .q0_ready(q0_ready), .q0_val(q0_val),
    .q1_id(q1_id), .q1_ready(q1_ready), .q1_val(q1_val),
    .mem_busy(mem_busy),
    .cmt0_valid(cmt0_valid), .cmt0_id(cmt0_id), .cmt0_rd(cmt0_rd), .cmt0_val(cmt0_val),
    .cmt1_valid(cmt1_valid), .cmt1_id(cmt1_id), .cmt1_rd(cmt1_rd), .cmt1_val(cmt1_val),
    .store_commit(store_commit), .br_valid(br_valid), .br_taken(br_taken),
    .br_correct(br_correct), .flush_out(flush_out), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a plain table of in-flight instructions plus ring pointers
  bit          m_valid [DEPTH];
  bit          m_done  [DEPTH];
  int          m_kind  [DEPTH];
  logic [4:0]  m_rd    [DEPTH];
  logic [31:0] m_pc    [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  bit          m_pred  [DEPTH];
  logic [31:0] m_val   [DEPTH];
  int m_head, m_tail, m_count;
  logic e_c0v, e_c1v, e_st, e_brv, e_brt, e_brc, e_fl;
  logic [IDX_W-1:0] e_c0id, e_c1id;
  logic [4:0] e_c0rd, e_c1rd;
  logic [31:0] e_c0val, e_c1val, e_flpc;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_done[i] = 0; m_kind[i] = 0; m_rd[i] = 0;
      m_pc[i] = 0; m_tgt[i] = 0; m_pred[i] = 0; m_val[i] = 0;
    end
    m_head = 0; m_tail = 0; m_count = 0;
    {e_c0v, e_c1v, e_st, e_brv, e_brt, e_brc, e_fl} = '0;
    e_c0id = 0; e_c1id = 0; e_c0rd = 0; e_c1rd = 0;
    e_c0val = 0; e_c1val = 0; e_flpc = 0;
  endtask

  function automatic logic [31:0] exp_qval(input int id);
    if (wb1_valid && wb1_id == id) return wb1_val;
    if (wb0_valid && wb0_id == id) return wb0_val;
    return m_val[id];
  endfunction

  function automatic logic exp_qrdy(input int id);
    return m_done[id] || (wb0_valid && wb0_id == id) || (wb1_valid && wb1_id == id);
  endfunction

  task automatic check_outputs();
    chk("full_out", full_out, m_count >= DEPTH - 1);
    chk("alloc_id", alloc_id, m_tail);
    chk("q0_ready", q0_ready, exp_qrdy(q0_id));
    chk("q0_val", q0_val, exp_qval(q0_id));
    chk("q1_ready", q1_ready, exp_qrdy(q1_id));
    chk("q1_val", q1_val, exp_qval(q1_id));
    chk("cmt0_valid", cmt0_valid, e_c0v);
    chk("cmt0_id", cmt0_id, e_c0id);
    chk("cmt0_rd", cmt0_rd, e_c0rd);
    chk("cmt0_val", cmt0_val, e_c0val);
    chk("cmt1_valid", cmt1_valid, e_c1v);
    chk("cmt1_id", cmt1_id, e_c1id);
    chk("cmt1_rd", cmt1_rd, e_c1rd);
    chk("cmt1_val", cmt1_val, e_c1val);
    chk("store_commit", store_commit, e_st);
    chk("br_valid", br_valid, e_brv);
    chk("br_taken", br_taken, e_brt);
    chk("br_correct", br_correct, e_brc);
    chk("flush_out", flush_out, e_fl);
    chk("flush_pc", flush_pc, e_flpc);
  endtask

  // One clock edge of behaviour; kinds: 0 alu/load, 1 store, 2 branch, 3 jalr
  task automatic model_step();
    int h, h1, k;
    bit c0, c1, mis, fl, aok;
    if (!rdy_in) begin
      e_c0v = 0; e_c1v = 0; e_st = 0; e_brv = 0; e_fl = 0;
      return;
    end
    h = m_head; h1 = (m_head + 1) % DEPTH; k = m_kind[h];
    c0 = m_valid[h] && m_done[h] && !(k == 1 && mem_busy);
    c1 = c0 && k == 0 && m_valid[h1] && m_done[h1] && m_kind[h1] == 0;
    mis = c0 && k == 2 && (m_val[h][0] != m_pred[h]);
    fl = mis || (c0 && k == 3);
    aok = alloc_valid && (m_count < DEPTH - 1) && !e_fl;
    e_c0v = c0; e_c1v = c1; e_st = c0 && k == 1; e_brv = c0 && k == 2; e_fl = fl;
    if (c0) begin
      e_c0id = h;
      e_c0rd = (k == 0 || k == 3) ? m_rd[h] : 5'd0;
      e_c0val = (k == 3) ? m_pc[h] + 4 : m_val[h];
      if (k == 2) begin e_brt = m_val[h][0]; e_brc = !mis; end
    end
    if (c1) begin e_c1id = h1; e_c1rd = m_rd[h1]; e_c1val = m_val[h1]; end
    if (fl) e_flpc = (k == 3) ? (m_val[h] & ~32'd1) : (m_val[h][0] ? m_tgt[h] : m_pc[h] + 4);
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
      m_head = 0; m_tail = 0; m_count = 0;
      return;
    end
    if (wb0_valid && m_valid[wb0_id]) begin m_done[wb0_id] = 1; m_val[wb0_id] = wb0_val; end
    if (wb1_valid && m_valid[wb1_id]) begin m_done[wb1_id] = 1; m_val[wb1_id] = wb1_val; end
    if (aok) begin
      m_valid[m_tail] = 1; m_done[m_tail] = 0; m_kind[m_tail] = alloc_kind;
      m_rd[m_tail] = alloc_rd; m_pc[m_tail] = alloc_pc; m_tgt[m_tail] = alloc_target;
      m_pred[m_tail] = alloc_pred;
      m_tail = (m_tail + 1) % DEPTH; m_count++;
    end
    if (c0) begin m_valid[h] = 0; m_count--; end
    if (c1) begin m_valid[h1] = 0; m_count--; end
    m_head = (m_head + int'(c0) + int'(c1)) % DEPTH;
  endtask

  task automatic idle();
    rdy_in = 1; alloc_valid = 0; alloc_kind = 0; alloc_rd = 0; alloc_pc = 0;
    alloc_target = 0; alloc_pred = 0; wb0_valid = 0; wb1_valid = 0; mem_busy = 0;
  endtask

  // Called away from the rising edge; returns with clk low and reset released
  task automatic do_reset();
    rst_in = 0; idle();
    model_reset();
    #1 check_outputs();
    #1 rst_in = 1;
  endtask

  task automatic cycle();
    #1 check_outputs();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic alloc(input int kind, input int rd, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit pred);
    idle(); alloc_valid = 1; alloc_kind = kind[1:0]; alloc_rd = rd[4:0];
    alloc_pc = pc; alloc_target = tgt; alloc_pred = pred;
    cycle();
  endtask

  initial begin
    #1 do_reset();
    chk("rst_alloc_id", alloc_id, 0);
    chk("rst_cmt0", cmt0_valid, 0);

    // Dual commit of two ALU results, then a lone third
    alloc(0, 1, 32'h0, 0, 0); alloc(0, 2, 32'h4, 0, 0); alloc(0, 3, 32'h8, 0, 0);
    idle(); wb0_valid = 1; wb0_id = 1; wb0_val = 32'h11; wb1_valid = 1; wb1_id = 0; wb1_val = 32'h10;
    cycle();
    idle(); wb1_valid = 1; wb1_id = 2; wb1_val = 32'h12;
    cycle();
    chk("dual_c0", {cmt0_valid, 3'b0, cmt0_id}, {1'b1, 3'b0, 4'd0});
    chk("dual_c0val", cmt0_val, 32'h10);
    chk("dual_c1", {cmt1_valid, 3'b0, cmt1_id}, {1'b1, 3'b0, 4'd1});
    chk("dual_c1rd", cmt1_rd, 2);
    idle(); cycle();
    chk("dual_c0b", {cmt0_valid, 3'b0, cmt0_id}, {1'b1, 3'b0, 4'd2});
    chk("dual_c1b", cmt1_valid, 0);

    // Fill to DEPTH-1, drop the extra alloc, then commit and wrap the tail
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) alloc(0, i + 1, 32'h1000 + 4 * i, 0, 0);
    chk("full_set", full_out, 1);
    chk("full_id", alloc_id, 15);
    alloc(0, 9, 32'h2000, 0, 0);
    chk("full_drop", alloc_id, 15);
    idle(); wb0_valid = 1; wb0_id = 0; wb0_val = 32'h77; cycle();
    idle(); cycle();
    chk("full_clear", full_out, 0);
    alloc(0, 4, 32'h3000, 0, 0);
    chk("tail_wrap", alloc_id, 0);

    // Mispredicted taken branch that actually falls through
    do_reset();
    alloc(2, 0, 32'h100, 32'h140, 1);
    idle(); wb0_valid = 1; wb0_id = 0; wb0_val = 32'h0; cycle();
    alloc(0, 5, 32'h500, 0, 0);
    chk("br_valid", br_valid, 1);
    chk("br_correct", br_correct, 0);
    chk("br_flush", flush_out, 1);
    chk("br_flush_pc", flush_pc, 32'h104);
    idle(); cycle();
    chk("br_after_id", alloc_id, 0);

    // Store held by a busy memory port; younger ALU must not pair with it
    do_reset();
    alloc(1, 0, 32'h40, 0, 0); alloc(0, 6, 32'h44, 0, 0);
    idle(); wb0_valid = 1; wb0_id = 0; wb0_val = 32'h5; wb1_valid = 1; wb1_id = 1; wb1_val = 32'h66;
    mem_busy = 1; cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); mem_busy = 1; cycle();
      chk("st_busy", cmt0_valid, 0);
    end
    idle(); cycle();
    chk("st_commit", store_commit, 1);
    chk("st_nopair", cmt1_valid, 0);
    idle(); cycle();
    chk("st_next", {cmt0_valid, 3'b0, cmt0_id}, {1'b1, 3'b0, 4'd1});

    // Jalr: link value pc+4, redirect to target with bit 0 cleared
    do_reset();
    alloc(3, 1, 32'h200, 0, 0);
    idle(); wb0_valid = 1; wb0_id = 0; wb0_val = 32'h301; cycle();
    idle(); cycle();
    chk("jalr_rd", cmt0_rd, 1);
    chk("jalr_val", cmt0_val, 32'h204);
    chk("jalr_flush", flush_out, 1);
    chk("jalr_pc", flush_pc, 32'h300);

    // Lookup bypass, then a two-cycle stall with a commit pending
    do_reset();
    for (int i = 0; i < 5; i++) alloc(0, i + 1, 32'h600 + 4 * i, 0, 0);
    idle(); q0_id = 4; wb1_valid = 1; wb1_id = 4; wb1_val = 32'hABCD;
    wb0_valid = 1; wb0_id = 0; wb0_val = 32'h5;
    #1 chk("q_bypass_rdy", q0_ready, 1);
    chk("q_bypass_val", q0_val, 32'hABCD);
    cycle();
    for (int i = 0; i < 2; i++) begin
      idle(); rdy_in = 0; alloc_valid = 1; alloc_rd = 9; wb0_valid = 1; wb0_id = 1; wb0_val = 32'hEE;
      cycle();
      chk("stall_cmt", cmt0_valid, 0);
      chk("stall_id", alloc_id, 5);
    end
    idle(); cycle();
    chk("resume_c0", {cmt0_valid, 3'b0, cmt0_id}, {1'b1, 3'b0, 4'd0});
    chk("resume_val", cmt0_val, 32'h5);

    // Random traffic with an asynchronous reset in the middle
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      if (n == 1500) do_reset();
      rdy_in = ($urandom_range(0, 9) != 0);
      mem_busy = ($urandom_range(0, 3) == 0);
      alloc_valid = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 19);
      alloc_kind = (r < 13) ? 2'd0 : (r < 16) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
      alloc_rd = 5'($urandom);
      alloc_pc = {$urandom, 2'b00};
      alloc_target = {$urandom, 2'b00};
      alloc_pred = 1'($urandom);
      wb0_valid = ($urandom_range(0, 9) < 6);
      wb0_id = IDX_W'((m_head + $urandom_range(0, 4)) % DEPTH);
      wb0_val = $urandom;
      wb1_valid = ($urandom_range(0, 9) < 5);
      wb1_id = ($urandom_range(0, 3) == 0) ? wb0_id : IDX_W'((m_head + $urandom_range(0, 4)) % DEPTH);
      wb1_val = $urandom;
      q0_id = IDX_W'($urandom);
      q1_id = ($urandom_range(0, 2) == 0) ? wb1_id : IDX_W'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "bench time limit reached");
  end

endmodule
